if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined CPU.
- Generates the PC and drives a single-outstanding-request instruction memory port.
- Delivers the instruction and PC+4 to the ID stage, where instr[15:0] feeds the sign extender and the register file.
- Honours stall from the hazard unit and redirect/flush from the branch/jump logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, PC/address width; 32 is the only supported value.

Ports:
clk_i  in  1  clock, all state updates on the rising edge
rst_i  in  1  synchronous active-high reset
imem_req_o  out  1  fetch request, held until imem_ack_i
imem_addr_o  out  32  fetch address, stable while imem_req_o=1
imem_ack_i  in  1  response valid; imem_data_i valid this cycle; may be the same cycle as req
imem_data_i  in  32  fetched instruction
stall_i  in  1  hazard stall: hold the IF/ID register and the PC
redirect_i  in  1  taken branch/jump: flush IF/ID and load a new PC
redirect_pc_i  in  32  target PC; bits [1:0] forced to 0
if_id_valid_o  out  1  IF/ID holds a real instruction
if_id_instr_o  out  32  instruction to ID
if_id_pc4_o  out  32  fetch address + 4

Behaviour:
- Reset (rst_i=1 at an edge):
  - pc=RESET_PC, req_addr=RESET_PC, state=FETCH.
  - if_id_valid_o=0, if_id_instr_o=32'h0, if_id_pc4_o=32'h0, skid buffer empty.
  - imem_req_o=1 from the first cycle after reset.
  - Reset mid-request discards any in-flight response.
- imem_req_o=1 in FETCH and DROP; 0 in BUF.
- imem_addr_o=req_addr. req_addr changes only on an ack cycle, or on a redirect while in BUF.

States:
- FETCH, ack, no stall: IF/ID loads {valid=1, data, req_addr+4}; pc and req_addr advance by 4; stay FETCH. Throughput is 1 instr/cycle with a zero-wait memory.
- FETCH, ack, stall_i=1: data and pc4 go to the skid buffer; IF/ID held; go BUF.
- FETCH, no ack: IF/ID bubble (valid<=0) unless stall_i=1, in which case hold.
- BUF, stall_i=0: IF/ID loads the buffer; pc and req_addr advance by 4; go FETCH.
- BUF, stall_i=1: hold.
- DROP: wait for ack, discard the data; then req_addr<=pc and go FETCH. IF/ID gets bubbles meanwhile.

Redirect (highest priority, overrides stall):
- IF/ID valid<=0 and pc<=redirect_pc_i & ~3.
- From FETCH without ack: go DROP; the old request stays asserted at the old address until ack.
- From FETCH with ack the same cycle: discard the data; req_addr<=target; go FETCH.
- From BUF: buffer discarded; req_addr<=target; go FETCH.
- From DROP: pc updated to the latest target; remain DROP.

Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined: adds outputs perf_fetch_o[31:0] and perf_bubble_o[31:0].
  - perf_fetch_o counts ack cycles whose data is accepted into IF/ID or the buffer.
  - perf_bubble_o counts cycles with if_id_valid_o=0 after reset.
  - Both reset to 0 and wrap.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC default
  - NOP_INSTR = 32'h0000_0000
  - fetch_state_t enum {FETCH, DROP, BUF}
  - INSTR_W = 32
- One natural sub-module: if_skid_buf, a 1-entry instr+pc4 holding register with load/clear/valid.

Test Plan:
- Reset, ack tied 1: if_id_pc4_o = 4, 8, 12 on consecutive cycles; valid=1 from the second cycle; imem_addr_o = 0, 4, 8.
- Ack on the first cycle of stall_i=1 (held 3 cycles) at addr 0x10: no loss. IF/ID keeps the 0x0C instruction; 0x10's data appears the cycle after stall drops; imem_req_o=0 during BUF.
- redirect_i with target 0x100 while a request to 0x20 is pending 2 more cycles: 0x20's data is never valid. The next valid IF/ID has pc4=0x104; imem_addr_o stays 0x20 until its ack.
- redirect_i with target 0x203 and a same-cycle ack: data discarded; next fetch address 0x200; valid=0 for one cycle.
- redirect_i and stall_i together in BUF: buffer dropped; fetch resumes at the target; IF/ID valid=0.
- pc at 32'hFFFF_FFFC, ack: pc4 output 0, next address 0. Reset asserted during DROP: first fetch address is RESET_PC and the stale ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC default, NOP encoding, fetch FSM states,
// and the PC-increment helper.
package cpu_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    BUF
  } fetch_state_t;

  // Wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched instruction and its PC+4, used
// when a memory response lands while the IF/ID register is stalled.
module if_skid_buf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= '0;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID pipeline register with a single-outstanding-request
// memory port. Define IF_ID_PERF_EN to add fetch/bubble performance counters.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               if_id_valid_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]        perf_fetch_o,
  output logic [31:0]        perf_bubble_o
`endif
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  req_pc4;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic               skid_load;
  logic               skid_clear;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;

  assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);
  assign req_pc4      = pc_plus4(req_addr);

  assign imem_req_o  = (state != BUF);
  assign imem_addr_o = req_addr;

  assign skid_load  = (state == FETCH) && imem_ack_i && stall_i && !redirect_i;
  assign skid_clear = (state == BUF) && (redirect_i || !stall_i);

  if_skid_buf #(
    .ADDR_W(ADDR_W)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_instr(imem_data_i),
    .load_pc4  (req_pc4),
    .valid     (skid_valid),
    .instr     (skid_instr),
    .pc4       (skid_pc4)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= '0;
    end else if (redirect_i) begin
      // A pending request cannot be withdrawn; DROP keeps it on the port
      // until its ack and fetches from the new pc afterwards.
      pc            <= redirect_tgt;
      if_id_valid_o <= 1'b0;
      if (state == BUF || (state == FETCH && imem_ack_i)) begin
        req_addr <= redirect_tgt;
        state    <= FETCH;
      end else if (state == FETCH) begin
        state <= DROP;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack_i) begin
            if (stall_i) begin
              state <= BUF;
            end else begin
              if_id_valid_o <= 1'b1;
              if_id_instr_o <= imem_data_i;
              if_id_pc4_o   <= req_pc4;
              pc            <= pc_plus4(pc);
              req_addr      <= req_pc4;
            end
          end else if (!stall_i) begin
            if_id_valid_o <= 1'b0;
          end
        end
        BUF: begin
          if (!stall_i) begin
            if_id_valid_o <= skid_valid;
            if_id_instr_o <= skid_instr;
            if_id_pc4_o   <= skid_pc4;
            pc            <= pc_plus4(pc);
            req_addr      <= req_pc4;
            state         <= FETCH;
          end
        end
        DROP: begin
          if_id_valid_o <= 1'b0;
          if (imem_ack_i) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_o  <= '0;
      perf_bubble_o <= '0;
    end else begin
      if ((state == FETCH) && imem_ack_i && !redirect_i)
        perf_fetch_o <= perf_fetch_o + 32'd1;
      if (!if_id_valid_o)
        perf_bubble_o <= perf_bubble_o + 32'd1;
    end
  end
`endif

endmodule
